// File: rtl/mem_arb_pkg.sv
// Shared constants, state encoding and transaction record for the IF/MEM memory-port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 64;
    localparam int INSTR_W        = 32;
    localparam int CNT_W          = 4;
    localparam int MEM_LAT_DEF    = 2;
    localparam int STARVE_MAX_DEF = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_D  = 1'b1;

    // Word address is kept from bit 2 up: bit 2 picks the fetch half, bits 31:3 address memory.
    typedef struct packed {
        logic                owner;
        logic                we;
        logic [ADDR_W-1:2]   addr;
        logic [DATA_W-1:0]   wdata;
    } txn_t;

    function automatic logic [INSTR_W-1:0] fetch_word(input logic hi, input logic [DATA_W-1:0] d);
        return hi ? d[63:32] : d[31:0];
    endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down counter that times the fixed memory latency; last flags the final wait cycle.
module mem_lat_counter
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             last
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency 64-bit memory between instruction fetch and the load/store port,
// with data priority, a fetch anti-starvation counter and per-requester stall outputs.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT    = MEM_LAT_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req,
    input  logic [ADDR_W-1:0]  if_addr,
    output logic               if_gnt,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_rdata,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [ADDR_W-1:0]  d_addr,
    input  logic [DATA_W-1:0]  d_wdata,
    output logic               d_gnt,
    output logic               d_valid,
    output logic [DATA_W-1:0]  d_rdata,
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               stall_if,
    output logic               stall_d,
    output logic [1:0]         dbg_state
);

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    txn_t               txn_q;
    logic [CNT_W-1:0]   starve_cnt;
    logic [INSTR_W-1:0] if_rdata_q;
    logic [DATA_W-1:0]  d_rdata_q;
    logic               idle;
    logic               done;
    logic               force_if;
    logic               lat_last;
    logic               addr_lsb_unused;

    assign addr_lsb_unused = ^{if_addr[1:0], d_addr[1:0]};

    assign idle     = (state == ST_IDLE);
    assign done     = (state == ST_DONE);
    assign force_if = if_req && (starve_cnt == CNT_W'(STARVE_MAX));

    // Handshake: a requester holds req (and its address/data) until its valid pulse; gnt is a
    // combinational accept in IDLE and the request is latched on that clock edge. Inputs seen
    // after the grant are ignored, and a dropped req still completes its access.
    assign d_gnt  = rst && idle && d_req && !force_if;
    assign if_gnt = rst && idle && if_req && (force_if || !d_req);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (if_gnt || d_gnt) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = (MEM_LAT == 1) ? ST_DONE : ST_WAIT;
            ST_WAIT:  if (lat_last) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    mem_lat_counter u_lat (
        .clk      (clk),
        .rst      (rst),
        .load     (state == ST_ISSUE),
        .load_val (CNT_W'(MEM_LAT - 1)),
        .dec      (state == ST_WAIT),
        .last     (lat_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            txn_q      <= '0;
            starve_cnt <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state <= state_nxt;
            if (if_gnt || d_gnt) begin
                txn_q.owner <= d_gnt ? OWNER_D : OWNER_IF;
                txn_q.we    <= d_gnt && d_we;
                txn_q.addr  <= d_gnt ? d_addr[ADDR_W-1:2] : if_addr[ADDR_W-1:2];
                txn_q.wdata <= d_gnt ? d_wdata : '0;
            end
            // Fetch is only starved while it is actually waiting behind data grants.
            if (idle) begin
                if (if_gnt || !if_req) begin
                    starve_cnt <= '0;
                end else if (d_gnt && (starve_cnt != CNT_W'(STARVE_MAX))) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end
            if (done && !txn_q.we) begin
                if (txn_q.owner == OWNER_IF) begin
                    if_rdata_q <= fetch_word(txn_q.addr[2], mem_rdata);
                end else begin
                    d_rdata_q <= mem_rdata;
                end
            end
        end
    end

    assign if_valid = done && (txn_q.owner == OWNER_IF);
    assign d_valid  = done && (txn_q.owner == OWNER_D);

    // Read data is bypassed in DONE so it is valid in the same cycle as the valid pulse.
    assign if_rdata = if_valid ? fetch_word(txn_q.addr[2], mem_rdata) : if_rdata_q;
    assign d_rdata  = (d_valid && !txn_q.we) ? mem_rdata : d_rdata_q;

    assign mem_en    = (state == ST_ISSUE);
    assign mem_we    = mem_en && txn_q.we;
    assign mem_addr  = mem_en ? {txn_q.addr[ADDR_W-1:3], 3'b000} : '0;
    assign mem_wdata = mem_we ? txn_q.wdata : '0;

    assign stall_if  = rst && if_req && !if_valid;
    assign stall_d   = rst && d_req && !d_valid;
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a latency-accurate memory model, a scoreboard fed at
// grant time and checked at mem_en / valid time, plus a second MEM_LAT=1 instance.
module tb_mem_port_arbiter;

    localparam int LAT0 = 2;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [63:0] wdata;
    } iss_t;

    logic        clk;
    logic        rst;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr;
    logic [63:0] d_wdata;
    logic        if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we, stall_if, stall_d;
    logic [31:0] if_rdata, mem_addr;
    logic [63:0] d_rdata, mem_wdata, mem_rdata;
    logic [1:0]  dbg_state;

    logic        if1_req, d1_req, d1_we;
    logic [31:0] if1_addr, d1_addr;
    logic [63:0] d1_wdata;
    logic        if1_gnt, if1_valid, d1_gnt, d1_valid, mem_en1, mem_we1, stall_if1, stall_d1;
    logic [31:0] if1_rdata, mem_addr1;
    logic [63:0] d1_rdata, mem_wdata1, mem_rdata1;
    logic [1:0]  dbg_state1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_en  = 0;
    int n_gnt = 0;

    logic [63:0] env_mem [64];
    logic [63:0] ref_mem [64];
    logic [63:0] rd_p0, rd_p1, rd1_p;
    logic        rd_v0 = 0, rd_v1 = 0, rd1_v = 0;

    logic [31:0] if_exp_q [$];
    logic [63:0] d_exp_q  [$];
    iss_t        iss_q    [$];
    int          lat_q    [$];
    logic        gnt_log  [$];
    int          gnt_cyc  [$];
    logic [31:0] last_if;
    logic [63:0] last_d, d_pred;

    mem_port_arbiter #(.MEM_LAT(LAT0), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_d(stall_d), .dbg_state(dbg_state)
    );

    mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(if1_req), .if_addr(if1_addr), .if_gnt(if1_gnt), .if_valid(if1_valid), .if_rdata(if1_rdata),
        .d_req(d1_req), .d_we(d1_we), .d_addr(d1_addr), .d_wdata(d1_wdata),
        .d_gnt(d1_gnt), .d_valid(d1_valid), .d_rdata(d1_rdata),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .stall_if(stall_if1), .stall_d(stall_d1), .dbg_state(dbg_state1)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] pat(input logic [5:0] i);
        return {32'hC0DE_0000 | {26'd0, i}, 32'h1234_5600 ^ {24'd0, 2'b00, i}};
    endfunction

    function automatic logic [31:0] half(input logic [63:0] d, input logic hi);
        return hi ? d[63:32] : d[31:0];
    endfunction

    // ---------------- memory models ----------------
    always @(posedge clk) begin
        if (mem_en && mem_we) env_mem[mem_addr[8:3]] <= mem_wdata;
        rd_p0 <= env_mem[mem_addr[8:3]];
        rd_v0 <= mem_en && !mem_we;
        rd_p1 <= rd_p0;
        rd_v1 <= rd_v0;
        rd1_p <= pat(mem_addr1[8:3]);
        rd1_v <= mem_en1 && !mem_we1;
    end
    assign mem_rdata  = rd_v1 ? rd_p1 : 64'hBAD0_BAD0_BAD0_BAD0;
    assign mem_rdata1 = rd1_v ? rd1_p : 64'hBAD1_BAD1_BAD1_BAD1;

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if_exp_q.delete(); d_exp_q.delete(); iss_q.delete(); lat_q.delete();
            last_if = '0; last_d = '0; d_pred = '0;
        end else begin
            check_val("gnt_excl", 64'(if_gnt & d_gnt), 64'd0);
            check_val("stall_if", 64'(stall_if), 64'(if_req & ~if_valid));
            check_val("stall_d", 64'(stall_d), 64'(d_req & ~d_valid));
            if (if_gnt) begin
                if_exp_q.push_back(half(ref_mem[if_addr[8:3]], if_addr[2]));
                iss_q.push_back(iss_t'{we: 1'b0, addr: {if_addr[31:3], 3'b000}, wdata: 64'd0});
                lat_q.push_back(cyc); gnt_log.push_back(1'b0); gnt_cyc.push_back(cyc); n_gnt++;
            end
            if (d_gnt) begin
                iss_q.push_back(iss_t'{we: d_we, addr: {d_addr[31:3], 3'b000}, wdata: d_wdata});
                if (d_we) begin
                    ref_mem[d_addr[8:3]] = d_wdata;
                end else begin
                    d_pred = ref_mem[d_addr[8:3]];
                end
                d_exp_q.push_back(d_pred);
                lat_q.push_back(cyc); gnt_log.push_back(1'b1); gnt_cyc.push_back(cyc); n_gnt++;
            end
            if (mem_en) begin
                n_en++;
                if (iss_q.size() == 0) check_val("mem_en_extra", 64'd1, 64'd0);
                else begin
                    iss_t e;
                    e = iss_q.pop_front();
                    check_val("mem_addr", 64'(mem_addr), 64'(e.addr));
                    check_val("mem_we", 64'(mem_we), 64'(e.we));
                    if (e.we) check_val("mem_wdata", mem_wdata, e.wdata);
                end
            end
            if (if_valid) begin
                if (if_exp_q.size() == 0) check_val("if_valid_extra", 64'd1, 64'd0);
                else begin
                    last_if = if_exp_q.pop_front();
                    check_val("if_rdata", 64'(if_rdata), 64'(last_if));
                    if (lat_q.size() != 0) check_val("if_lat", 64'(cyc - lat_q.pop_front()), 64'(1 + LAT0));
                end
            end else check_val("if_hold", 64'(if_rdata), 64'(last_if));
            if (d_valid) begin
                if (d_exp_q.size() == 0) check_val("d_valid_extra", 64'd1, 64'd0);
                else begin
                    last_d = d_exp_q.pop_front();
                    check_val("d_rdata", d_rdata, last_d);
                    if (lat_q.size() != 0) check_val("d_lat", 64'(cyc - lat_q.pop_front()), 64'(1 + LAT0));
                end
            end else check_val("d_hold", d_rdata, last_d);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_sig(input int kind, input string tag);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            case (kind)
                0:       seen = if_gnt;
                1:       seen = d_gnt;
                2:       seen = if_valid;
                3:       seen = d_valid;
                default: seen = mem_en;
            endcase
        end
        if (!seen) check_val({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    // Called just after a rising edge; returns just after a rising edge with req still high.
    task automatic f_op(input logic [31:0] a);
        if_req = 1'b1; if_addr = a;
        wait_sig(0, "if_gnt");
        @(posedge clk); #1;
        if_addr = $urandom;
        wait_sig(2, "if_valid");
        @(posedge clk); #1;
    endtask

    task automatic d_op(input logic we, input logic [31:0] a, input logic [63:0] wd);
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
        wait_sig(1, "d_gnt");
        @(posedge clk); #1;
        d_addr = $urandom; d_wdata = {$urandom, $urandom}; d_we = 1'($urandom_range(0, 1));
        wait_sig(3, "d_valid");
        @(posedge clk); #1;
    endtask

    task automatic check_order(input string tag, input logic [7:0] exp_bits, input int n);
        check_val({tag, "_n"}, 64'(gnt_log.size()), 64'(n));
        for (int i = 0; i < n; i++)
            if (i < gnt_log.size()) check_val(tag, 64'(gnt_log[i]), 64'(exp_bits[i]));
    endtask

    task automatic check_reset_outs(input string tag);
        check_val({tag, "_gnt"}, 64'({if_gnt, d_gnt}), 64'd0);
        check_val({tag, "_valid"}, 64'({if_valid, d_valid}), 64'd0);
        check_val({tag, "_stall"}, 64'({stall_if, stall_d}), 64'd0);
        check_val({tag, "_mem_ctl"}, 64'({mem_en, mem_we}), 64'd0);
        check_val({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check_val({tag, "_mem_wdata"}, mem_wdata, 64'd0);
        check_val({tag, "_if_rdata"}, 64'(if_rdata), 64'd0);
        check_val({tag, "_d_rdata"}, d_rdata, 64'd0);
        check_val({tag, "_state"}, 64'(dbg_state), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c0, c1, c_en;
        bit seen;
        logic [63:0] keep;
        int n_en_before;

        for (int i = 0; i < 64; i++) begin
            env_mem[i] = pat(6'(i));
            ref_mem[i] = pat(6'(i));
        end
        rst = 1'b0;
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        if_addr = 32'h0; d_addr = 32'h0; d_wdata = 64'h0;
        if1_req = 1'b0; d1_req = 1'b0; d1_we = 1'b0;
        if1_addr = 32'h0; d1_addr = 32'h0; d1_wdata = 64'h0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("reset");
        if_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;

        // 1: single fetch, upper word of the 0x100 doubleword
        gnt_log.delete(); gnt_cyc.delete();
        @(posedge clk); #1;
        f_op(32'h0000_0104);
        if_req = 1'b0;
        check_val("t1_if_rdata", 64'(if_rdata), 64'(pat(6'h20) >> 32));

        // 2: simultaneous requests, data wins, fetch follows
        gnt_log.delete(); gnt_cyc.delete();
        @(posedge clk); #1;
        fork
            begin d_op(1'b0, 32'h0000_0008, 64'h0); d_req = 1'b0; end
            begin f_op(32'h0000_0010); if_req = 1'b0; end
        join
        check_order("t2_order", 8'b0000_0001, 2);

        // 3: continuous data traffic, fetch forced on the fifth grant
        gnt_log.delete(); gnt_cyc.delete();
        @(posedge clk); #1;
        fork
            begin
                for (int k = 0; k < 5; k++) d_op(1'b0, 32'h80 + 32'(k * 8), 64'h0);
                d_req = 1'b0;
            end
            begin f_op(32'h0000_0050); if_req = 1'b0; end
        join
        check_order("t3_order", 8'b0010_1111, 6);
        for (int i = 1; i < gnt_cyc.size(); i++)
            check_val("t3_gap", 64'(gnt_cyc[i] - gnt_cyc[i-1]), 64'(2 + LAT0));

        // 4: store leaves d_rdata alone, then read it back
        @(posedge clk); #1;
        d_op(1'b0, 32'h0000_0040, 64'h0);
        keep = ref_mem[8];
        n_en_before = n_en;
        d_op(1'b1, 32'h0000_0020, 64'hDEAD_BEEF_0123_4567);
        d_req = 1'b0;
        check_val("t4_en_count", 64'(n_en - n_en_before), 64'd1);
        check_val("t4_keep", d_rdata, keep);
        @(posedge clk); #1;
        d_op(1'b0, 32'h0000_0020, 64'h0);
        d_req = 1'b0;
        check_val("t4_readback", d_rdata, 64'hDEAD_BEEF_0123_4567);

        // 5: MEM_LAT=1 instance, ISSUE straight to DONE
        @(posedge clk); #1;
        d1_req = 1'b1; d1_we = 1'b0; d1_addr = 32'h0000_0048;
        c0 = -1; c1 = -1; c_en = -1;
        for (int n = 0; n < 50 && c1 < 0; n++) begin
            @(negedge clk);
            if (d1_gnt && c0 < 0) c0 = cyc;
            if (mem_en1) c_en = cyc;
            if (d1_valid) begin
                c1 = cyc;
                check_val("t5_rdata", d1_rdata, pat(6'h09));
            end
            if (c0 >= 0 && cyc == c0 + 1) check_val("t5_issue", 64'(dbg_state1), 64'd1);
        end
        check_val("t5_en_cyc", 64'(c_en - c0), 64'd1);
        check_val("t5_lat", 64'(c1 - c0), 64'd2);
        @(posedge clk); #1;
        d1_req = 1'b0;

        // random mix of fetches, loads and stores
        for (int k = 0; k < 12; k++) begin
            int op;
            op = $urandom_range(0, 2);
            @(posedge clk); #1;
            case (op)
                0: begin f_op(32'($urandom_range(0, 127)) << 2); if_req = 1'b0; end
                1: begin d_op(1'b0, 32'($urandom_range(0, 15)) << 3, 64'h0); d_req = 1'b0; end
                default: begin d_op(1'b1, 32'($urandom_range(0, 15)) << 3, {$urandom, $urandom}); d_req = 1'b0; end
            endcase
        end

        // 6: reset while waiting on memory
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0018;
        wait_sig(4, "t6_mem_en");
        @(posedge clk); #1;
        check_val("t6_in_wait", 64'(dbg_state), 64'd2);
        rst = 1'b0;
        #1;
        check_reset_outs("t6");
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (if_valid || d_valid) seen = 1'b1;
        end
        check_val("t6_no_valid", 64'(seen), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_val("t6_regrant", 64'(d_gnt), 64'd1);
        wait_sig(3, "t6_valid");
        @(posedge clk); #1;
        d_req = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        check_val("en_count", 64'(n_en), 64'(n_gnt));
        check_val("q_empty", 64'(if_exp_q.size() + d_exp_q.size() + iss_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
